// File: rtl/button_input.sv
// button_input: debounced front panel buttons with LED toggles and a
// mode button that distinguishes short and long presses.
//
// Ports:
//   clock       system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   button_n    6 raw asynchronous push-buttons, active-low
//   mode_n      raw asynchronous mode push-button, active-low
//   led_enable  per-button toggle state
//   press_pulse one-clock strobe per accepted button press
//   mtne_mode   maintenance-mode flag, toggled by a long mode press
//   mode_state  current mode-button FSM state (debug visibility)
//
// Handshake: press_pulse is a valid-only strobe with no ready. Each set
// bit is high for exactly one clock per accepted press, and led_enable
// already shows the toggled value in that same clock.
module button_input #(
  parameter int TICK_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int LONG_TICKS     = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] button_n,
  input  logic       mode_n,
  output logic [5:0] led_enable,
  output logic [5:0] press_pulse,
  output logic       mtne_mode,
  output logic [1:0] mode_state
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HOLD         = 2'd1,
    WAIT_RELEASE = 2'd2
  } mode_state_t;

  // Bit 6 is the mode button, bits 5:0 are the six panel buttons.
  logic [6:0]    raw;
  logic [6:0]    sync1;
  logic [6:0]    sync2;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [6:0]    db_level;
  logic [DW-1:0] db_cnt [7];
  logic [DW-1:0] db_inc [7];
  logic [6:0]    accept;
  logic [5:0]    press_now;

  mode_state_t   state;
  mode_state_t   state_next;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_next;
  logic          mode_pressed;
  logic          mtne_toggle;
  logic          short_clear;

  assign raw = {mode_n, button_n};

  // Synchronizers reset to the released level so a button held through
  // reset is seen as a fresh press afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // A new level is accepted on the tick where the run of consecutive
  // disagreeing samples reaches DEBOUNCE_TICKS.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      db_inc[i] = db_cnt[i] + DW'(1);
      accept[i] = tick && (sync2[i] != db_level[i]) &&
                  (db_inc[i] == DW'(DEBOUNCE_TICKS));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      db_level <= '1;
      for (int i = 0; i < 7; i++) begin
        db_cnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < 7; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (accept[i]) begin
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_inc[i];
        end
      end
    end
  end

  // Only released->pressed acceptances (new level 0) count as presses.
  assign press_now    = accept[5:0] & ~sync2[5:0];
  assign mode_pressed = ~db_level[6];

  always_comb begin
    state_next  = state;
    hold_next   = hold_cnt;
    mtne_toggle = 1'b0;
    short_clear = 1'b0;
    case (state)
      IDLE: begin
        if (mode_pressed) begin
          state_next = HOLD;
          hold_next  = '0;
        end
      end
      HOLD: begin
        if (!mode_pressed) begin
          short_clear = 1'b1;
          state_next  = IDLE;
        end else if (tick) begin
          if (hold_cnt + HW'(1) == HW'(LONG_TICKS)) begin
            hold_next   = HW'(LONG_TICKS);
            mtne_toggle = 1'b1;
            state_next  = WAIT_RELEASE;
          end else begin
            hold_next = hold_cnt + HW'(1);
          end
        end
      end
      WAIT_RELEASE: begin
        // hold_cnt stays saturated here; only the release matters.
        if (!mode_pressed) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      led_enable  <= '0;
      press_pulse <= '0;
      mtne_mode   <= 1'b0;
    end else begin
      state       <= state_next;
      hold_cnt    <= hold_next;
      press_pulse <= press_now;
      // A short-press clear wins over any toggle landing in the same clock.
      led_enable  <= short_clear ? 6'b0 : (led_enable ^ press_now);
      if (mtne_toggle) begin
        mtne_mode <= ~mtne_mode;
      end
    end
  end

  assign mode_state = state;

endmodule

// File: tb/tb_button_input.sv
// tb_button_input: randomized bench for button_input with a tick-level
// reference model and a scoreboard of expected press and mode events.
module tb_button_input;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int LONG     = 8;
  localparam int PW       = 44;  // {edge[31:0], press[5:0], led[5:0]}
  localparam int MW       = 33;  // {edge[31:0], mtne}

  logic       clock;
  logic       reset;
  logic [5:0] button_n;
  logic       mode_n;
  logic [5:0] led_enable;
  logic [5:0] press_pulse;
  logic       mtne_mode;
  logic [1:0] mode_state;

  button_input #(
    .TICK_DIV      (TICK_DIV),
    .DEBOUNCE_TICKS(DEB),
    .LONG_TICKS    (LONG)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .button_n   (button_n),
    .mode_n     (mode_n),
    .led_enable (led_enable),
    .press_pulse(press_pulse),
    .mtne_mode  (mtne_mode),
    .mode_state (mode_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int edge_cnt;
  always @(posedge clock) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [PW-1:0] press_exp_q[$];
  logic [MW-1:0] mtne_exp_q[$];
  int n_checks;
  int n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one call per sample tick) ----------------
  logic [6:0] m_hist[$];
  logic [6:0] m_deb;
  logic [5:0] m_led;
  logic       m_mtne;
  int         m_tick;
  bit         m_holding;
  bit         m_long_done;
  int         m_hold_start;

  task automatic model_reset();
    m_hist.delete();
    m_deb        = '1;
    m_led        = '0;
    m_mtne       = 1'b0;
    m_tick       = 0;
    m_holding    = 1'b0;
    m_long_done  = 1'b0;
    m_hold_start = 0;
  endtask

  task automatic model_tick(input logic [5:0] b, input logic m);
    logic [6:0] acc;
    logic [6:0] old;
    logic [5:0] press;
    bit         all_diff;
    m_tick++;
    m_hist.push_back({m, b});
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    acc = '0;
    // An input flips once its last DEB samples all disagree with its level.
    for (int i = 0; i < 7; i++) begin
      all_diff = (m_hist.size() == DEB);
      for (int k = 0; k < m_hist.size(); k++)
        if (m_hist[k][i] == m_deb[i]) all_diff = 1'b0;
      acc[i] = all_diff;
    end
    old   = m_deb;
    m_deb = m_deb ^ acc;
    press = acc[5:0] & old[5:0];
    m_led = m_led ^ press;
    if (press != 0) press_exp_q.push_back({32'(TICK_DIV * m_tick), press, m_led});
    if (acc[6] && !m_deb[6]) begin
      m_holding    = 1'b1;
      m_long_done  = 1'b0;
      m_hold_start = m_tick;
    end else if (m_holding) begin
      if (!m_long_done && (m_tick - m_hold_start == LONG)) begin
        m_long_done = 1'b1;
        m_mtne      = ~m_mtne;
        mtne_exp_q.push_back({32'(TICK_DIV * m_tick), m_mtne});
      end
      if (acc[6] && m_deb[6]) begin
        if (!m_long_done) m_led = '0;
        m_holding = 1'b0;
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic mtne_prev;
  always @(negedge clock) begin
    mtne_prev <= mtne_mode;
    if (!reset) begin
      if (press_pulse != 6'b0) begin
        if (press_exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'(press_pulse), 32'd0);
        end else begin
          logic [PW-1:0] e;
          e = press_exp_q.pop_front();
          chk("pulse_edge", 32'(edge_cnt), e[43:12]);
          chk("pulse_bits", 32'(press_pulse), 32'(e[11:6]));
          chk("pulse_led", 32'(led_enable), 32'(e[5:0]));
        end
      end
      if (mtne_mode !== mtne_prev) begin
        if (mtne_exp_q.size() == 0) begin
          chk("unexpected_mtne", 32'(mtne_mode), 32'(mtne_prev));
        end else begin
          logic [MW-1:0] e;
          e = mtne_exp_q.pop_front();
          chk("mtne_edge", 32'(edge_cnt), e[32:1]);
          chk("mtne_val", 32'(mtne_mode), 32'(e[0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [5:0] cur_b;
  logic       cur_m;

  // Called at the falling edge right after a tick edge; drives the value
  // seen by the next tick and checks settled state just before that tick.
  task automatic apply_slot(input logic [5:0] b, input logic m);
    logic [5:0] exp_led;
    logic       exp_mtne;
    button_n = b;
    mode_n   = m;
    exp_led  = m_led;
    exp_mtne = m_mtne;
    model_tick(b, m);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("slot_led", 32'(led_enable), 32'(exp_led));
    chk("slot_mtne", 32'(mtne_mode), 32'(exp_mtne));
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic repeat_slot(input int n, input logic [5:0] b, input logic m);
    for (int k = 0; k < n; k++) apply_slot(b, m);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_led", 32'(led_enable), 32'd0);
    chk("rst_pulse", 32'(press_pulse), 32'd0);
    chk("rst_mtne", 32'(mtne_mode), 32'd0);
    chk("rst_state", 32'(mode_state), 32'd0);
    reset = 1'b0;
  endtask

  task automatic rand_slots(input int n, input bit rand_mode);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 5) == 0) cur_b[i] = ~cur_b[i];
      if (rand_mode && $urandom_range(0, 7) == 0) cur_m = ~cur_m;
      apply_slot(cur_b, cur_m);
    end
  endtask

  task automatic rand_btn_fixed_mode(input int n, input logic m);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 5) == 0) cur_b[i] = ~cur_b[i];
      cur_m = m;
      apply_slot(cur_b, cur_m);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    button_n = '1;
    mode_n   = 1'b1;
    cur_b    = '1;
    cur_m    = 1'b1;
    @(negedge clock);
    do_reset();

    repeat_slot(2, 6'b111111, 1'b1);

    // Button 2 with a one-tick bounce before settling low.
    repeat_slot(2, 6'b111011, 1'b1);
    repeat_slot(1, 6'b111111, 1'b1);
    repeat_slot(5, 6'b111011, 1'b1);
    repeat_slot(4, 6'b111111, 1'b1);

    // Buttons 0 and 5 together, twice.
    repeat_slot(4, 6'b011110, 1'b1);
    repeat_slot(4, 6'b111111, 1'b1);
    repeat_slot(4, 6'b011110, 1'b1);
    repeat_slot(4, 6'b111111, 1'b1);

    // Random button activity.
    rand_slots(60, 1'b0);

    // Short mode presses while buttons keep moving.
    for (int r = 0; r < 3; r++) begin
      rand_btn_fixed_mode(8, 1'b1);
      rand_btn_fixed_mode($urandom_range(3, 6), 1'b0);
      rand_btn_fixed_mode(5, 1'b1);
    end

    // Long mode presses: 20 ticks, then a random long hold.
    rand_btn_fixed_mode(6, 1'b1);
    rand_btn_fixed_mode(20, 1'b0);
    rand_btn_fixed_mode(6, 1'b1);
    rand_btn_fixed_mode($urandom_range(11, 20), 1'b0);
    rand_btn_fixed_mode(6, 1'b1);

    // Everything random, including bouncy mode presses.
    rand_slots(100, 1'b1);
    cur_b = '1;
    cur_m = 1'b1;
    repeat_slot(6, 6'b111111, 1'b1);

    // Reset while button 3 is two ticks into its debounce, then keep it low.
    repeat_slot(2, 6'b110111, 1'b1);
    do_reset();
    repeat_slot(4, 6'b110111, 1'b1);
    repeat_slot(4, 6'b111111, 1'b1);

    // Mode held through reset is treated as a fresh press.
    repeat_slot(2, 6'b111111, 1'b0);
    do_reset();
    repeat_slot(12, 6'b111111, 1'b0);
    repeat_slot(5, 6'b111111, 1'b1);

    repeat (4) @(negedge clock);
    chk("press_q_empty", 32'(press_exp_q.size()), 32'd0);
    chk("mtne_q_empty", 32'(mtne_exp_q.size()), 32'd0);
    chk("final_led", 32'(led_enable), 32'(m_led));
    chk("final_mtne", 32'(mtne_mode), 32'(m_mtne));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_input.md
BUTTON_INPUT -- requirements
Module: button_input

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clocks per debounce sample tick.
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 4, consecutive disagreeing ticks needed to accept a new level.
REQ-003 SHALL have parameter LONG_TICKS, default 50, debounced ticks of mode-button hold that count as a long press.
REQ-004 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port button_n  input  6  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-007 SHALL have port mode_n  input  1  raw asynchronous mode push-button, active-low.
REQ-008 SHALL have port led_enable  output  6  per-button toggle state, registered.
REQ-009 SHALL have port press_pulse  output  6  one-clock strobe per accepted button press, registered.
REQ-010 SHALL have port mtne_mode  output  1  maintenance-mode flag toggled by a long press, registered.

Function
REQ-011 SHALL pass each of the 7 raw inputs through a 2-flop synchronizer before any other use.
REQ-012 SHALL run a tick counter 0..TICK_DIV-1, asserting an internal tick for exactly one clock when the count equals TICK_DIV-1, then wrapping to 0.
REQ-013 SHALL keep per input a debounced level and a debounce counter; the counter changes only on tick cycles.
REQ-014 SHALL, on a tick where the synchronized level equals the debounced level, clear that input's debounce counter to 0.
REQ-015 SHALL, on a tick where they differ, increment the counter and, when the incremented value equals DEBOUNCE_TICKS, load the debounced level from the synchronized level and clear the counter.
REQ-016 SHALL, in the clock after a button's debounced level goes released->pressed, pulse the matching press_pulse bit high for exactly one clock and invert the matching led_enable bit in that same clock.
REQ-017 SHALL ignore pressed->released transitions of the 6 buttons (no pulse, no toggle).
REQ-018 SHALL handle several buttons accepted in the same clock independently, producing all pulses and toggles in that clock.
REQ-019 SHALL control the mode button with a state machine: IDLE, HOLD, WAIT_RELEASE.
REQ-020 IDLE: on debounced mode press, go to HOLD with hold counter = 0.
REQ-021 HOLD: increment hold counter on each tick; when it reaches LONG_TICKS, invert mtne_mode once and go to WAIT_RELEASE.
REQ-022 HOLD: on debounced release before LONG_TICKS (short press), clear led_enable to 6'b0 and return to IDLE.
REQ-023 WAIT_RELEASE: hold counter saturates, no further action; on debounced release return to IDLE without clearing led_enable.
REQ-024 SHALL give the short-press clear priority over any led_enable toggle in the same clock (result 0); press_pulse still asserts.
REQ-025 SHALL size counters to hold TICK_DIV-1, DEBOUNCE_TICKS and LONG_TICKS without overflow.

Reset
REQ-026 SHALL, while reset is high at a clock edge, set led_enable=0, press_pulse=0, mtne_mode=0, state=IDLE, and clear the tick, debounce and hold counters.
REQ-027 SHALL reset synchronizer flops and debounced levels to released (1), so an input held pressed through reset produces a press after DEBOUNCE_TICKS ticks once reset falls.
REQ-028 SHALL abandon any debounce or hold in progress when reset asserts mid-operation; no pulse or toggle occurs for it.

Verification (TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=8)
REQ-029 Reset with all inputs released -> all outputs 0; tick asserts on clocks 3, 7, 11... counting from reset deassertion.
REQ-030 button_n[2] low, bouncing high for 1 tick mid-way, then steady low -> press_pulse[2] exactly one clock only after 3 consecutive low ticks; led_enable=6'b000100.
REQ-031 button_n[0] and button_n[5] pressed together, released, pressed again -> press_pulse=6'b100001 in the same clock both times; led_enable 6'b100001, then 6'b000000.
REQ-032 led_enable=6'b001011, mode_n low for 4 debounced ticks then released -> led_enable=0, mtne_mode stays 0.
REQ-033 mode_n held low for 20 ticks -> mtne_mode goes 0->1 exactly once at the 8th hold tick; after release led_enable unchanged; repeat -> mtne_mode back to 0.
REQ-034 reset pulsed while button_n[3] is 2 ticks into debounce -> no press_pulse; if still low after reset, press_pulse[3] after 3 ticks.
